// File: rtl/vending_machine_param.sv
// Coin-operated vending controller with parameterised price (5c units).
// Vends when credit reaches PRICE_N; pays change or refunds as single dime/nickel pulses.
module vending_machine_param #(
   parameter int PRICE_N  = 4,
   parameter int CREDIT_W = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_nickle,
   input  logic                i_dime,
   input  logic                i_quarter,
   input  logic                i_cancel,
   output logic                o_soda,
   output logic                o_change_dime,
   output logic                o_change_nickle,
   output logic                o_reject,
   output logic [CREDIT_W-1:0] o_credit,
   output logic                o_busy
);

   typedef enum logic [1:0] {COLLECT, VEND, CHANGE, REFUND} state_t;

   localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE_N);
   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_N);
   localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
   localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(2);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                reject_q, reject_d;
   logic                soda_q, dime_q, nickle_q, busy_q;
   logic [1:0]          n_coins;
   logic [CREDIT_W:0]   coin_val, sum;
   logic                paying_d;

   always_comb begin
      n_coins  = 2'(i_nickle) + 2'(i_dime) + 2'(i_quarter);
      coin_val = '0;
      if (i_nickle)  coin_val = (CREDIT_W+1)'(1);
      if (i_dime)    coin_val = (CREDIT_W+1)'(2);
      if (i_quarter) coin_val = (CREDIT_W+1)'(5);
      sum      = {1'b0, credit_q} + coin_val;
      state_d  = state_q;
      credit_d = credit_q;
      reject_d = 1'b0;
      case (state_q)
         COLLECT: begin
            // A coin arriving alongside cancel is never credited, whether or not the cancel acts.
            if (i_cancel) begin
               reject_d = (n_coins != 2'd0);
               if (credit_q != '0) state_d = REFUND;
            end else if (n_coins > 2'd1) begin
               reject_d = 1'b1;
            end else if (n_coins == 2'd1) begin
               credit_d = sum[CREDIT_W-1:0];
               if (sum >= PRICE_X) state_d = VEND;
            end
         end
         VEND: begin
            reject_d = (n_coins != 2'd0);
            credit_d = credit_q - PRICE_C;
            state_d  = (credit_q == PRICE_C) ? COLLECT : CHANGE;
         end
         default: begin
            reject_d = (n_coins != 2'd0);
            credit_d = (credit_q >= TWO_C) ? credit_q - TWO_C : '0;
            if (credit_q <= TWO_C) state_d = COLLECT;
         end
      endcase
      paying_d = (state_d == CHANGE) || (state_d == REFUND);
   end

   // Outputs are registered from the next-state values so they line up with state_q/credit_q.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= COLLECT;
         credit_q <= '0;
         reject_q <= 1'b0;
         soda_q   <= 1'b0;
         dime_q   <= 1'b0;
         nickle_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         reject_q <= reject_d;
         soda_q   <= (state_d == VEND);
         dime_q   <= paying_d && (credit_d >= TWO_C);
         nickle_q <= paying_d && (credit_d == ONE_C);
         busy_q   <= (state_d != COLLECT);
      end
   end

   assign o_soda          = soda_q;
   assign o_change_dime   = dime_q;
   assign o_change_nickle = nickle_q;
   assign o_reject        = reject_q;
   assign o_credit        = credit_q;
   assign o_busy          = busy_q;

   a_credit_max: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      {1'b0, credit_q} <= (CREDIT_W+1)'(PRICE_N + 4));

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param at default parameters (price 20c).
module tb_vending_machine_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       nk = 1'b0, dm = 1'b0, qt = 1'b0, cn = 1'b0;
   logic       soda, cdime, cnick, rej, busy;
   logic [3:0] credit;
   int         n_cmp = 0;
   int         n_err = 0;

   vending_machine_param #(.PRICE_N(4), .CREDIT_W(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_nickle(nk), .i_dime(dm), .i_quarter(qt), .i_cancel(cn),
      .o_soda(soda), .o_change_dime(cdime), .o_change_nickle(cnick),
      .o_reject(rej), .o_credit(credit), .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, let the edge sample them, then release them.
   task automatic step(input logic n, input logic d, input logic q, input logic c);
      nk = n; dm = d; qt = q; cn = c;
      @(posedge clk);
      #1;
      nk = 0; dm = 0; qt = 0; cn = 0;
   endtask

   // Check the whole output vector: soda, dime, nickel, reject, busy, credit.
   task automatic outs(input string tag, input logic s, input logic d, input logic n,
                       input logic r, input logic b, input logic [3:0] c);
      chk({tag, ".soda"},   32'(soda),   32'(s));
      chk({tag, ".dime"},   32'(cdime),  32'(d));
      chk({tag, ".nick"},   32'(cnick),  32'(n));
      chk({tag, ".rej"},    32'(rej),    32'(r));
      chk({tag, ".busy"},   32'(busy),   32'(b));
      chk({tag, ".credit"}, 32'(credit), 32'(c));
   endtask

   initial begin
      #12;
      outs("reset", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      outs("idle", 0, 0, 0, 0, 0, 0);

      // four nickels
      step(1, 0, 0, 0); outs("s1.n1", 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0); outs("s1.n2", 0, 0, 0, 0, 0, 2);
      step(1, 0, 0, 0); outs("s1.n3", 0, 0, 0, 0, 0, 3);
      step(1, 0, 0, 0); outs("s1.vend", 1, 0, 0, 0, 1, 4);
      step(0, 0, 0, 0); outs("s1.done", 0, 0, 0, 0, 0, 0);

      // quarter from zero
      step(0, 0, 1, 0); outs("s2.vend", 1, 0, 0, 0, 1, 5);
      step(0, 0, 0, 0); outs("s2.nick", 0, 0, 1, 0, 1, 1);
      step(0, 0, 0, 0); outs("s2.done", 0, 0, 0, 0, 0, 0);

      // dime then quarter, remainder 3
      step(0, 1, 0, 0); outs("s3.dime", 0, 0, 0, 0, 0, 2);
      step(0, 0, 1, 0); outs("s3.vend", 1, 0, 0, 0, 1, 7);
      step(0, 0, 0, 0); outs("s3.cd",   0, 1, 0, 0, 1, 3);
      step(0, 0, 0, 0); outs("s3.cn",   0, 0, 1, 0, 1, 1);
      step(0, 0, 0, 0); outs("s3.done", 0, 0, 0, 0, 0, 0);

      // cancel at credit 3
      step(1, 0, 0, 0); outs("s4.n",    0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0); outs("s4.d",    0, 0, 0, 0, 0, 3);
      step(0, 0, 0, 1); outs("s4.rd",   0, 1, 0, 0, 1, 3);
      step(0, 0, 0, 0); outs("s4.rn",   0, 0, 1, 0, 1, 1);
      step(0, 0, 0, 0); outs("s4.done", 0, 0, 0, 0, 0, 0);

      // double coin, coin during VEND, coin with cancel at zero credit
      step(1, 0, 0, 0); outs("s5.n",     0, 0, 0, 0, 0, 1);
      step(0, 1, 1, 0); outs("s5.dbl",   0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0); outs("s5.clr",   0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0); outs("s5.d",     0, 0, 0, 0, 0, 3);
      step(1, 0, 0, 0); outs("s5.vend",  1, 0, 0, 0, 1, 4);
      step(0, 1, 0, 0); outs("s5.vrej",  0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0); outs("s5.clr2",  0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1); outs("s5.cz",    0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0); outs("s5.clr3",  0, 0, 0, 0, 0, 0);

      // maximum credit: 3 + quarter = 8, remainder 4 -> two dimes
      step(0, 1, 0, 0); outs("mx.d",    0, 0, 0, 0, 0, 2);
      step(1, 0, 0, 0); outs("mx.n",    0, 0, 0, 0, 0, 3);
      step(0, 0, 1, 0); outs("mx.vend", 1, 0, 0, 0, 1, 8);
      step(0, 0, 0, 1); outs("mx.cd1",  0, 1, 0, 0, 1, 4);
      step(0, 0, 0, 0); outs("mx.cd2",  0, 1, 0, 0, 1, 2);
      step(0, 0, 0, 0); outs("mx.done", 0, 0, 0, 0, 0, 0);

      // reset during second change cycle
      step(0, 1, 0, 0); outs("s6.dime", 0, 0, 0, 0, 0, 2);
      step(0, 0, 1, 0); outs("s6.vend", 1, 0, 0, 0, 1, 7);
      step(0, 0, 0, 0); outs("s6.cd",   0, 1, 0, 0, 1, 3);
      step(0, 0, 0, 0); outs("s6.cn",   0, 0, 1, 0, 1, 1);
      #1 rst_n = 1'b0;
      #1 outs("s6.rst", 0, 0, 0, 0, 0, 0);
      #1 rst_n = 1'b1;
      step(0, 0, 0, 0); outs("s6.post1", 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0); outs("s6.post2", 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0); outs("s6.alive", 0, 0, 0, 0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
